// File: rtl/fifo_rd_credit_packetizer_if.sv
// Signal bundle between the packetizer, the FWFT FIFO read port and the router input port.
// Pure wiring, no latency of its own.
// Backpressure is carried by rd_empty (data side) and credit_in/credits (router side).
interface fifo_rd_credit_packetizer_if #(
  parameter int DataWidth = 32,
  parameter int DstWidth  = 4,
  parameter int CredWidth = 3
);
  // FIFO read side
  logic                 rd_req;
  logic [DataWidth-1:0] rd_data;
  logic                 rd_empty;
  // Configuration
  logic [DstWidth-1:0]  cfg_dst;
  // Router flit side
  logic                 flit_valid;
  logic [DataWidth-1:0] flit_data;
  logic [1:0]           flit_type;
  logic                 credit_in;
  // Status
  logic [CredWidth-1:0] credits;
  logic                 busy;
  logic                 err_credit_ovf;

  // Packetizer view
  modport master (
    output rd_req,
    input  rd_data,
    input  rd_empty,
    input  cfg_dst,
    output flit_valid,
    output flit_data,
    output flit_type,
    input  credit_in,
    output credits,
    output busy,
    output err_credit_ovf
  );

  // Environment view (FIFO, router, configuration)
  modport slave (
    input  rd_req,
    output rd_data,
    output rd_empty,
    output cfg_dst,
    input  flit_valid,
    input  flit_data,
    input  flit_type,
    output credit_in,
    input  credits,
    input  busy,
    input  err_credit_ovf
  );
endinterface

// File: rtl/fifo_rd_credit_packetizer.sv
// Frames FWFT FIFO words into NoC packets (head + PacketLength payload flits, last is tail).
// Latency: one cycle from FIFO pop (or head decision) to registered flit_valid.
// Backpressure: stalls with a bubble whenever the FIFO is empty or no router credit remains.
module fifo_rd_credit_packetizer #(
  parameter int DataWidth    = 32,
  parameter int PacketLength = 4,
  parameter int NumCredits   = 4,
  parameter int DstWidth     = 4
) (
  input logic                        clk,
  input logic                        rst,
  fifo_rd_credit_packetizer_if.master bus
);

  localparam int CredWidth = $clog2(NumCredits + 1);
  localparam int CntWidth  = (PacketLength > 1) ? $clog2(PacketLength) : 1;

  localparam logic [CredWidth-1:0] CredMax = CredWidth'(NumCredits);
  localparam logic [CredWidth-1:0] CredOne = CredWidth'(1);
  localparam logic [CntWidth-1:0]  CntLast = CntWidth'(PacketLength - 1);
  localparam logic [CntWidth-1:0]  CntOne  = CntWidth'(1);

  localparam logic [1:0] TypeBody = 2'b00;
  localparam logic [1:0] TypeHead = 2'b01;
  localparam logic [1:0] TypeTail = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t               state;
  logic [CntWidth-1:0]  cnt;
  logic [7:0]           seq;
  logic [CredWidth-1:0] credits;
  logic                 err_ovf;
  logic                 flit_valid_q;
  logic [DataWidth-1:0] flit_data_q;
  logic [1:0]           flit_type_q;
  logic                 busy_q;

  logic                 issue;
  logic [DataWidth-1:0] head_word;

  // A flit goes out only when the FIFO has a word and the router has a free slot.
  // In IDLE this also guarantees the first payload word is already waiting.
  assign issue = !bus.rd_empty && (credits != '0);

  // Pops happen only for payload flits; the head never consumes a FIFO word.
  assign bus.rd_req = (state == PAYLOAD) && issue;

  assign bus.flit_valid     = flit_valid_q;
  assign bus.flit_data      = flit_data_q;
  assign bus.flit_type      = flit_type_q;
  assign bus.credits        = credits;
  assign bus.busy           = busy_q;
  assign bus.err_credit_ovf = err_ovf;

  // Build the head flit: destination in the top bits, sequence number in the low byte.
  always_comb begin
    head_word = '0;
    head_word[DataWidth-1 -: DstWidth] = bus.cfg_dst;
    head_word[7:0] = seq;
  end

  // Packet framing FSM with registered flit outputs; stalls hold state and insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      seq          <= '0;
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      flit_type_q  <= TypeBody;
      busy_q       <= 1'b0;
    end else begin
      flit_valid_q <= issue;
      if (issue) begin
        case (state)
          IDLE: begin
            flit_data_q <= head_word;
            flit_type_q <= TypeHead;
            cnt         <= '0;
            state       <= PAYLOAD;
            busy_q      <= 1'b1;
          end
          PAYLOAD: begin
            flit_data_q <= bus.rd_data;
            if (cnt == CntLast) begin
              flit_type_q <= TypeTail;
              seq         <= seq + 8'd1;
              cnt         <= '0;
              state       <= IDLE;
              busy_q      <= 1'b0;
            end else begin
              flit_type_q <= TypeBody;
              cnt         <= cnt + CntOne;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Credit counter: spend one per issued flit, regain one per credit_in; a return with
  // the counter already full is dropped and flagged sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CredMax;
      err_ovf <= 1'b0;
    end else begin
      case ({issue, bus.credit_in})
        2'b10: credits <= credits - CredOne;
        2'b01: begin
          if (credits == CredMax) begin
            err_ovf <= 1'b1;
          end else begin
            credits <= credits + CredOne;
          end
        end
        default: begin
          credits <= credits;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_credit_packetizer.sv
// Self-checking bench for fifo_rd_credit_packetizer with a queue-based FIFO and router model.
// One cycle per call of cycle(); outputs checked 1 ns after the rising edge.
// Credits are returned by a randomised router model with configurable delay.
module tb_fifo_rd_credit_packetizer;
  localparam int DW   = 32;
  localparam int PL   = 4;
  localparam int NC   = 4;
  localparam int DSTW = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_rd_credit_packetizer_if #(.DataWidth(DW), .DstWidth(DSTW), .CredWidth(CW)) bus ();

  fifo_rd_credit_packetizer #(
    .DataWidth(DW), .PacketLength(PL), .NumCredits(NC), .DstWidth(DSTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO contents (front = FWFT word) and router credit-return schedule
  logic [31:0] fq[$];
  int          due[$];
  int          last_due;
  int          cyc = 0;
  bit          ret_en;
  int          dmin, dmax;
  bit          dst_rand;
  logic [3:0]  dst_fixed;

  // Reference model: position in packet (0 = expecting head, k = k-th payload next)
  int m_pos, m_seq, m_cred;
  bit m_ovf;

  int rdreq_cnt, head_cnt, pay_cnt;
  logic [31:0] words[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_seq = 0;
    m_cred = NC;
    m_ovf = 0;
    due.delete();
    last_due = 0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back($urandom);
  endtask

  // One clock: drive at the falling edge, check rd_req, apply the model at the edge,
  // check registered outputs shortly after.
  task automatic cycle(input bit force_cin);
    bit          cin, issue;
    int          junk, nd;
    logic [3:0]  dst;
    logic [31:0] exp_data;
    logic [1:0]  exp_type;
    cin = force_cin;
    if (cin) begin
      if (due.size() > 0) junk = due.pop_front();
    end else if (ret_en && due.size() > 0 && due[0] <= cyc) begin
      cin = 1'b1;
      junk = due.pop_front();
    end
    dst = dst_rand ? 4'($urandom) : dst_fixed;
    bus.credit_in = cin;
    bus.cfg_dst   = dst;
    bus.rd_empty  = (fq.size() == 0);
    bus.rd_data   = (fq.size() > 0) ? fq[0] : $urandom;
    #1;
    issue = (fq.size() > 0) && (m_cred > 0);
    chk("rd_req", {31'b0, bus.rd_req}, {31'b0, issue && (m_pos != 0)});
    if (bus.rd_req) rdreq_cnt++;
    @(posedge clk);
    exp_data = '0;
    exp_type = 2'b00;
    if (issue) begin
      if (m_pos == 0) begin
        exp_type = 2'b01;
        exp_data = {dst, 20'h0, 8'(m_seq)};
        m_pos = 1;
      end else begin
        exp_data = fq.pop_front();
        if (m_pos == PL) begin
          exp_type = 2'b10;
          m_pos = 0;
          m_seq = (m_seq + 1) % 256;
        end else begin
          exp_type = 2'b00;
          m_pos++;
        end
      end
      nd = cyc + $urandom_range(dmin, dmax);
      if (nd < last_due) nd = last_due;
      last_due = nd;
      due.push_back(nd);
    end
    if (issue && !cin) m_cred--;
    else if (!issue && cin) begin
      if (m_cred == NC) m_ovf = 1;
      else m_cred++;
    end
    cyc++;
    #1;
    chk("flit_valid", {31'b0, bus.flit_valid}, {31'b0, issue});
    if (issue) begin
      chk("flit_type", {30'b0, bus.flit_type}, {30'b0, exp_type});
      chk("flit_data", bus.flit_data, exp_data);
    end
    chk("credits", {29'b0, bus.credits}, m_cred);
    chk("busy", {31'b0, bus.busy}, {31'b0, m_pos != 0});
    chk("err_ovf", {31'b0, bus.err_credit_ovf}, {31'b0, m_ovf});
    if (bus.flit_valid && bus.flit_type == 2'b01) head_cnt++;
    if (bus.flit_valid && bus.flit_type != 2'b01) pay_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.credit_in = 1'b0;
    bus.rd_empty = 1'b1;
    bus.rd_data = '0;
    bus.cfg_dst = '0;
    ret_en = 0; dmin = 1; dmax = 1;
    dst_rand = 0; dst_fixed = 4'd3;
    rdreq_cnt = 0; head_cnt = 0; pay_cnt = 0;
    model_reset();

    // 1. reset state, then idle with an empty FIFO
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_credits", {29'b0, bus.credits}, 32'd4);
    chk("rst_flit_valid", {31'b0, bus.flit_valid}, 32'd0);
    chk("rst_rd_req", {31'b0, bus.rd_req}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_err", {31'b0, bus.err_credit_ovf}, 32'd0);
    rst = 1'b0;
    repeat (4) cycle(0);

    // 2. one packet, dst 3, credits returned two cycles after each flit
    push_words(4);
    ret_en = 1; dmin = 2; dmax = 2;
    rdreq_cnt = 0;
    cycle(0);
    chk("first_head", bus.flit_data, 32'h3000_0000);
    repeat (11) cycle(0);
    chk("rd_req_pulses", rdreq_cnt, 32'd4);

    // 3. credit starvation: four flits, then a single credit releases the tail
    ret_en = 0;
    push_words(8);
    repeat (8) cycle(0);
    chk("starved_credits", {29'b0, bus.credits}, 32'd0);
    chk("starved_valid", {31'b0, bus.flit_valid}, 32'd0);
    cycle(1);
    cycle(0);
    chk("released_tail", {30'b0, bus.flit_type}, 32'd2);
    chk("released_credits", {29'b0, bus.credits}, 32'd0);
    ret_en = 1; dmin = 1; dmax = 3;
    repeat (20) cycle(0);

    // 4. FIFO underrun mid-packet, resume, then back-to-back packets
    dst_rand = 1;
    push_words(2);
    repeat (10) cycle(0);
    chk("underrun_busy", {31'b0, bus.busy}, 32'd1);
    chk("underrun_valid", {31'b0, bus.flit_valid}, 32'd0);
    push_words(2);
    repeat (6) cycle(0);
    dmin = 1; dmax = 1;
    push_words(8);
    for (int i = 0; i < 30; i++) begin
      cycle(0);
      if (bus.flit_valid && bus.flit_type == 2'b10) break;
    end
    cycle(0);
    chk("b2b_head", {29'b0, bus.flit_valid, bus.flit_type}, 32'h5);
    repeat (12) cycle(0);

    // 5. credit overflow while idle, then credit return coincident with an issue
    repeat (10) cycle(0);
    cycle(1);
    chk("ovf_set", {31'b0, bus.err_credit_ovf}, 32'd1);
    chk("ovf_credits", {29'b0, bus.credits}, 32'd4);
    repeat (3) cycle(0);
    chk("ovf_sticky", {31'b0, bus.err_credit_ovf}, 32'd1);
    ret_en = 0;
    push_words(4);
    cycle(0);
    cycle(0);
    chk("pre_coincide", {29'b0, bus.credits}, 32'd2);
    cycle(1);
    chk("coincide", {29'b0, bus.credits}, 32'd2);
    ret_en = 1;
    repeat (12) cycle(0);

    // 6. asynchronous reset mid-packet, restart, then sequence-number wrap
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    for (int i = 0; i < 8; i++) fq.push_back(words[i]);
    pay_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0);
      if (pay_cnt == 2) break;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.flit_valid}, 32'd0);
    chk("arst_data", bus.flit_data, 32'd0);
    chk("arst_credits", {29'b0, bus.credits}, 32'd4);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_rd_req", {31'b0, bus.rd_req}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    head_cnt = 0;
    cycle(0);
    chk("restart_head_seq", {24'b0, bus.flit_data[7:0]}, 32'd0);
    chk("restart_head_type", {30'b0, bus.flit_type}, 32'd1);
    cycle(0);
    chk("restart_payload", bus.flit_data, words[2]);
    for (int i = 0; i < 2000; i++) begin
      if (fq.size() < 4) push_words(1);
      cycle(0);
      if (bus.flit_valid && bus.flit_type == 2'b01 && head_cnt == 257) begin
        chk("seq_wrap", {24'b0, bus.flit_data[7:0]}, 32'd0);
        break;
      end
    end
    chk("wrap_reached", head_cnt, 32'd257);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
